// File: rtl/responder_memoria.sv
// ---------------------------------------------------------------------------
// responder_memoria
//   Single-port word memory that answers processor requests after a fixed
//   wait. A request is latched in IDLE. The wait counter is then loaded with
//   LATENCY-1 for a load or 0 for a store, and the FSM walks through
//   IDLE -> WAIT -> RESP. The access itself takes place on the edge that
//   enters RESP, and RESP is the single cycle in which Ready is high.
//
// Parameters
//   LATENCY  read wait cycles, legal range 1..7
//   DEPTH    number of 16-bit words
//
// Ports
//   Clock    in   rising-edge clock
//   Resetn   in   asynchronous active-low reset
//   Req      in   one-cycle request strobe
//   Write    in   1 = store, 0 = load (sampled with Req)
//   ADDR     in   16-bit word address (sampled with Req)
//   WDATA    in   16-bit store data (sampled with Req)
//   DIN      out  registered load data; holds until the next load completes
//   Ready    out  one-cycle completion pulse
//   Busy     out  registered, high while a request is in flight
//   Err      out  out-of-range address pulse, coincident with Ready
//   Overrun  out  sticky: Req arrived while Busy
// ---------------------------------------------------------------------------
module responder_memoria #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 128
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] DIN,
  output logic        Ready,
  output logic        Busy,
  output logic        Err,
  output logic        Overrun
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] din_q, din_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  logic [15:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             done;    // this edge moves WAIT -> RESP
  logic             mem_we;

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (32'(addr_q) < DEPTH);

  // NOTE: every signal written in this block gets a default first. Without
  // that, any path that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    din_d     = din_q;
    overrun_d = overrun_q;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          addr_d  = ADDR;
          wdata_d = WDATA;
          write_d = Write;
          cnt_d   = Write ? 3'd0 : CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          done    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // busy_q is high in both WAIT and RESP, so a Req in the RESP cycle also
    // counts as an overrun. That Req is not latched because the FSM only
    // accepts requests in IDLE.
    if (Req && busy_q) overrun_d = 1'b1;

    // Only a completing load updates DIN. An out-of-range load returns zero.
    if (done && !write_q) din_d = in_range ? mem[idx] : 16'h0000;

    mem_we  = done && write_q && in_range;
    ready_d = done;
    err_d   = done && !in_range;
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever order the blocks run.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      write_q   <= 1'b0;
      din_q     <= 16'h0000;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset. Its contents
  // must survive Resetn, and leaving it unreset lets it map onto RAM. A store
  // aborted by reset never writes, because reset has already pulled state_q
  // back to IDLE.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign DIN     = din_q;
  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign Err     = err_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_responder_memoria.sv
// ---------------------------------------------------------------------------
// tb_responder_memoria
//   Three instances of responder_memoria, with LATENCY = 2, 1 and 7, share
//   one clock and one reset. Each instance has its own request signals.
//   Stimulus pushes the expected response (completion cycle, DIN, Err) into
//   a per-instance queue. A monitor pops one entry per Ready and compares
//   it. A Ready that arrives with nothing queued is a failure, and so is Err
//   without Ready.
// ---------------------------------------------------------------------------
module tb_responder_memoria;

  typedef struct {
    int          cyc;
    logic [15:0] din;
    logic        err;
    string       tag;
  } exp_t;

  localparam int LAT [3] = '{2, 1, 7};

  logic        Clock;
  logic        Resetn;
  logic        req   [3];
  logic        wr    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] din   [3];
  logic        ready [3];
  logic        busy  [3];
  logic        err   [3];
  logic        ovr   [3];

  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  logic [15:0] last_din [3];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];

  responder_memoria #(.LATENCY(2), .DEPTH(128)) u_l2 (
    .Clock(Clock), .Resetn(Resetn), .Req(req[0]), .Write(wr[0]),
    .ADDR(addr[0]), .WDATA(wdata[0]), .DIN(din[0]), .Ready(ready[0]),
    .Busy(busy[0]), .Err(err[0]), .Overrun(ovr[0])
  );

  responder_memoria #(.LATENCY(1), .DEPTH(128)) u_l1 (
    .Clock(Clock), .Resetn(Resetn), .Req(req[1]), .Write(wr[1]),
    .ADDR(addr[1]), .WDATA(wdata[1]), .DIN(din[1]), .Ready(ready[1]),
    .Busy(busy[1]), .Err(err[1]), .Overrun(ovr[1])
  );

  responder_memoria #(.LATENCY(7), .DEPTH(128)) u_l7 (
    .Clock(Clock), .Resetn(Resetn), .Req(req[2]), .Write(wr[2]),
    .ADDR(addr[2]), .WDATA(wdata[2]), .DIN(din[2]), .Ready(ready[2]),
    .Busy(busy[2]), .Err(err[2]), .Overrun(ovr[2])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // cyc names the cycle. Stimulus and the monitor both read it on the falling edge.
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [15:0] d, input logic e, input string tag);
    exp_t x;
    x.cyc = c;
    x.din = d;
    x.err = e;
    x.tag = tag;
    return x;
  endfunction

  function automatic void push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int d, output exp_t e);
    bit ok;
    ok = 1'b0;
    e  = mk(0, 16'h0000, 1'b0, "none");
    case (d)
      0:       if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  // Monitor: one queue entry per Ready pulse.
  always @(negedge Clock) begin : monitor
    exp_t e;
    bit   ok;
    for (int d = 0; d < 3; d++) begin
      if (ready[d] === 1'b1) begin
        ok = pop(d, e);
        if (!ok) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready dut%0d: got Ready=1 at cycle %0d, expected no response", d, cyc);
        end else begin
          check({e.tag, " ready_cycle"}, cyc, e.cyc);
          check({e.tag, " din"}, din[d], e.din);
          check({e.tag, " err"}, err[d], e.err);
        end
      end else if (err[d] !== 1'b0 && Resetn === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL err_without_ready dut%0d: got Err=%b, expected 0 (cycle %0d)", d, err[d], cyc);
      end
    end
  end

  // Issue one request at the current falling edge. The task returns at the
  // first IDLE cycle, where a back-to-back request may start at once.
  task automatic issue(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_din, input bit exp_err, input string tag);
    push(d, mk(cyc + (w ? 2 : LAT[d] + 1), exp_din, exp_err, tag));
    if (!w) last_din[d] = exp_din;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge Clock);
    req[d] = 1'b0;
    check({tag, " busy_set"}, busy[d], 1'b1);
    repeat (w ? 2 : LAT[d] + 1) @(negedge Clock);
    check({tag, " busy_clear"}, busy[d], 1'b0);
  endtask

  task automatic store(input int d, input logic [15:0] a, input logic [15:0] wd,
                       input bit exp_err, input string tag);
    issue(d, 1'b1, a, wd, last_din[d], exp_err, tag);
  endtask

  task automatic load(input int d, input logic [15:0] a, input logic [15:0] exp_din,
                      input bit exp_err, input string tag);
    issue(d, 1'b0, a, 16'h0000, exp_din, exp_err, tag);
  endtask

  // Assert reset at a falling edge. The reset values are checked at once,
  // before any clock edge arrives.
  task automatic pulse_reset(input string tag);
    Resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check({tag, " din"},     din[d],   16'h0000);
      check({tag, " ready"},   ready[d], 1'b0);
      check({tag, " busy"},    busy[d],  1'b0);
      check({tag, " err"},     err[d],   1'b0);
      check({tag, " overrun"}, ovr[d],   1'b0);
      last_din[d] = 16'h0000;
    end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'h0000; wdata[d] = 16'h0000;
      last_din[d] = 16'h0000;
    end
    @(negedge Clock);
    pulse_reset("por");
    @(negedge Clock);

    // Preload, then a store followed by a load of the same word.
    store(0, 16'h0000, 16'hC0DE, 1'b0, "st0");
    store(0, 16'h0001, 16'h00AA, 1'b0, "st1");
    store(0, 16'h0005, 16'hBEEF, 1'b0, "st5");
    load (0, 16'h0005, 16'hBEEF, 1'b0, "ld5");

    // Out-of-range load and store. The store must not alias onto word 0.
    load (0, 16'h0080, 16'h0000, 1'b1, "ld_oor");
    store(0, 16'h0080, 16'hFFFF, 1'b1, "st_oor");
    load (0, 16'h0000, 16'hC0DE, 1'b0, "ld0_after_oor");

    // DIN holds its last load value through a store and idle cycles.
    load (0, 16'h0001, 16'h00AA, 1'b0, "ld1");
    store(0, 16'h0002, 16'h5555, 1'b0, "st2_hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("din_hold_idle", din[0], 16'h00AA);
    end
    load (0, 16'h0002, 16'h5555, 1'b0, "ld2");

    // Overrun: a second Req one cycle after an accepted load is ignored.
    check("overrun_clear_before", ovr[0], 1'b0);
    push(0, mk(cyc + 3, 16'hBEEF, 1'b0, "ld5_ovr"));
    last_din[0] = 16'hBEEF;
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0005;
    @(negedge Clock);
    addr[0] = 16'h0001;
    @(negedge Clock);
    req[0] = 1'b0;
    repeat (2) @(negedge Clock);
    check("overrun_set", ovr[0], 1'b1);
    load (0, 16'h0001, 16'h00AA, 1'b0, "ld1_after_ovr");
    check("overrun_sticky", ovr[0], 1'b1);

    // A store aborted by reset in WAIT must not write.
    store(0, 16'h0003, 16'h1234, 1'b0, "st3");
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0003; wdata[0] = 16'hDEAD;
    @(negedge Clock);
    req[0] = 1'b0;
    pulse_reset("rst_store_abort");
    @(negedge Clock);

    // A load aborted by reset in WAIT produces no Ready.
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0003;
    @(negedge Clock);
    req[0] = 1'b0;
    pulse_reset("rst_load_abort");
    repeat (4) @(negedge Clock);
    check("din_zero_after_reset", din[0], 16'h0000);
    load (0, 16'h0003, 16'h1234, 1'b0, "ld3_after_reset");

    // LATENCY = 1: back-to-back loads start at the IDLE edge.
    store(1, 16'h0007, 16'h7777, 1'b0, "l1_st7");
    store(1, 16'h0004, 16'h0444, 1'b0, "l1_st4");
    load (1, 16'h0007, 16'h7777, 1'b0, "l1_ld7");
    load (1, 16'h0004, 16'h0444, 1'b0, "l1_ld4_b2b");
    check("l1_no_overrun", ovr[1], 1'b0);

    // LATENCY = 7: same sequence.
    store(2, 16'h0007, 16'h7007, 1'b0, "l7_st7");
    store(2, 16'h0004, 16'h0407, 1'b0, "l7_st4");
    load (2, 16'h0007, 16'h7007, 1'b0, "l7_ld7");
    load (2, 16'h0004, 16'h0407, 1'b0, "l7_ld4_b2b");
    check("l7_no_overrun", ovr[2], 1'b0);

    // LATENCY = 1: a Req in the RESP cycle is ignored and flags overrun.
    push(1, mk(cyc + 2, 16'h7777, 1'b0, "l1_ld7_resp_req"));
    last_din[1] = 16'h7777;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0007;
    @(negedge Clock);
    req[1] = 1'b0;
    @(negedge Clock);
    req[1] = 1'b1; addr[1] = 16'h0004;
    @(negedge Clock);
    req[1] = 1'b0;
    check("l1_resp_req_not_accepted", busy[1], 1'b0);
    check("l1_resp_req_overrun", ovr[1], 1'b1);

    repeat (10) @(negedge Clock);
    check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/responder_memoria.md
RESPONDER_MEMORIA -- requirements
Module: responder_memoria

Interface
REQ-001 Parameter LATENCY, default 2, read wait cycles from request to data valid; legal range 1..7.
REQ-002 Parameter DEPTH, default 128, number of 16-bit words; word index is ADDR[6:0].
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Req  input  1  one-cycle request strobe from the processor, sampled on the clock edge.
REQ-006 Write  input  1  request type, sampled with Req: 1 = store, 0 = load.
REQ-007 ADDR  input  16  word address, sampled with Req.
REQ-008 WDATA  input  16  store data, sampled with Req.
REQ-009 DIN  output  16  load data to the processor; registered.
REQ-010 Ready  output  1  one-cycle completion pulse for the accepted request.
REQ-011 Busy  output  1  high while a request is in flight; registered.
REQ-012 Err  output  1  one-cycle pulse, coincident with Ready, for an out-of-range address.
REQ-013 Overrun  output  1  sticky flag: Req arrived while Busy.

Function
REQ-014 The FSM has three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, Req=1 latches ADDR, WDATA and Write, sets Busy=1, loads the wait counter with LATENCY-1 for a load or 0 for a store, then enters WAIT.
REQ-016 In WAIT, a nonzero counter decrements by 1 each cycle; a zero counter causes a move to RESP on the next edge.
REQ-017 On entering RESP: a load updates DIN with mem[ADDR[6:0]]; a store writes WDATA to mem[ADDR[6:0]] and leaves DIN unchanged.
REQ-018 In RESP, Ready=1 for exactly one cycle, after which the FSM returns to IDLE with Busy=0.
REQ-019 Load latency: Ready is high LATENCY+1 cycles after the Req edge, and DIN is valid in that same cycle.
REQ-020 Store latency: Ready is high 2 cycles after the Req edge; a load issued after that Ready sees the new data.
REQ-021 DIN holds its last load value until the next load completes; stores and idle cycles do not change it.
REQ-022 Out-of-range address (ADDR[15:7] != 0): a load returns DIN=16'h0000, a store leaves memory unchanged, Err=1 with Ready, timing unchanged.
REQ-023 Req while Busy=1 (including the RESP cycle) is ignored: the in-flight request is unaffected, and Overrun is set and stays set until reset.
REQ-024 Req in the cycle after RESP (IDLE) is accepted normally, so back-to-back loads have a throughput of one per LATENCY+2 cycles.
REQ-025 Req=0 in IDLE: no state change, Ready=0, Err=0.
REQ-026 Memory contents are not initialised by reset; the bench preloads memory through stores.

Reset
REQ-027 Resetn=0 immediately forces FSM=IDLE, counter=0, Busy=0, Ready=0, Err=0, Overrun=0, DIN=16'h0000, and clears the latched request.
REQ-028 Reset during WAIT aborts the request: no Ready is generated, and a pending store is not written.
REQ-029 Memory array contents are retained across reset.
REQ-030 The first Req is accepted on the first rising edge after Resetn is deasserted.

Verification
REQ-031 LATENCY=2: store 16'hBEEF to 5, then load 5 -> store Ready at cycle +2; load Ready at cycle +3 with DIN=16'hBEEF; Err=0.
REQ-032 Load from ADDR=16'h0080 -> Ready and Err together at cycle +3, DIN=16'h0000; store to 16'h0080 leaves mem[0] unchanged.
REQ-033 Req pulsed one cycle after an accepted load -> Overrun=1 and stays set; exactly one Ready, carrying the first load's data.
REQ-034 Store 16'h1234 to 3, then pull Resetn low during a load of 3 in WAIT -> no Ready; after release, a load of 3 returns 16'h1234 and DIN reads 0 before it.
REQ-035 LATENCY=1 and LATENCY=7: loads of a preloaded address -> Ready at cycle +2 and +8 respectively; back-to-back requests are accepted at the IDLE edge.
REQ-036 Load of 1 returns 16'h00AA, then store 16'h5555 to 2 -> DIN stays 16'h00AA through the store and idle cycles.
